rr_grant_arbiter: RTL and testbench

Round-robin arbiter that shares one resource among N requesters and drives a registered one-hot grant. A request seen while idle is granted on the next clock edge, so `req |=> gnt` holds from IDLE. The owner keeps the grant while it holds its request, up to MAX_HOLD cycles when others are waiting. It sits between the requesting stimulus/agent blocks and the shared datapath port, and its grant protocol is written so the bench can check it directly with SVA non-overlapped implications.

---
 rtl/rr_grant_arbiter.sv | 116 +++++++++++
 tb/tb_rr_grant_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, per-owner hold limit and
// a mandatory idle gap between successive grants.
module rr_grant_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8,
  localparam int unsigned IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [N-1:0] One = 1;

  typedef enum logic {StIdle, StGrant} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] id_q, id_d;

  logic           found;
  logic [IDW-1:0] winner;
  int unsigned    idx;
  logic           others;
  logic           release_now;

  // First requester at or after ptr, wrapping mod N.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  assign others      = |(req & ~(One << owner_q));
  assign release_now = !req[owner_q] || ((hold_q == HW'(MAX_HOLD)) && others);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    id_d    = id_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          owner_d = winner;
          ptr_d   = (winner == IDW'(N - 1)) ? '0 : winner + 1'b1;
          hold_d  = HW'(1);
          gnt_d   = One << winner;
          valid_d = 1'b1;
          id_d    = winner;
        end else begin
          gnt_d   = '0;
          valid_d = 1'b0;
          id_d    = '0;
        end
      end
      StGrant: begin
        if (release_now) begin
          state_d = StIdle;
          hold_d  = '0;
          gnt_d   = '0;
          valid_d = 1'b0;
          id_d    = '0;
        end else if (hold_q != HW'(MAX_HOLD)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_id    = id_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench: instance a uses MAX_HOLD=8, instance b uses MAX_HOLD=2 for
// the round-robin rotation sequence.
module tb_rr_grant_arbiter;

  logic       clk;
  logic       rst_a, rst_b;
  logic [3:0] req_a, req_b;
  logic [3:0] gnt_a, gnt_b;
  logic       gv_a, gv_b;
  logic [1:0] id_a, id_b;

  int total = 0;
  int bad   = 0;

  rr_grant_arbiter #(.N(4), .MAX_HOLD(8)) dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .req       (req_a),
    .gnt       (gnt_a),
    .gnt_valid (gv_a),
    .gnt_id    (id_a)
  );

  rr_grant_arbiter #(.N(4), .MAX_HOLD(2)) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .req       (req_b),
    .gnt       (gnt_b),
    .gnt_valid (gv_b),
    .gnt_id    (id_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  a_onehot: assert property (@(posedge clk) disable iff (rst_a) $onehot0(gnt_a))
    else $error("FAIL assert onehot0 gnt=%b", gnt_a);
  a_valid: assert property (@(posedge clk) disable iff (rst_a) gv_a == |gnt_a)
    else $error("FAIL assert gnt_valid=%b gnt=%b", gv_a, gnt_a);
  a_idle_grant: assert property (@(posedge clk) disable iff (rst_a)
    (!gv_a && |req_a) |=> gv_a)
    else $error("FAIL assert idle request not granted");
  // Grants never hand off directly between two requesters.
  a_no_handoff: assert property (@(posedge clk) disable iff (rst_a)
    (gv_a && $past(gv_a)) |-> gnt_a == $past(gnt_a))
    else $error("FAIL assert back-to-back handoff gnt=%b", gnt_a);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_a(input string tag, input logic [3:0] g, input logic [1:0] id);
    chk({tag, ".gnt"}, 32'(gnt_a), 32'(g));
    chk({tag, ".valid"}, 32'(gv_a), 32'(|g));
    chk({tag, ".id"}, 32'(id_a), 32'(id));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_gnt [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                              4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000,
                              4'b0001};
  logic [1:0] rr_id  [13] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0,
                              2'd2, 2'd2, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0};

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    req_a = 4'b1111;
    req_b = 4'b0000;

    // Reset with all requesting, then first grant goes to requester 0.
    tick(); exp_a("rst0", 4'b0000, 2'd0);
    tick(); exp_a("rst1", 4'b0000, 2'd0);
    rst_a = 1'b0;
    tick(); exp_a("first", 4'b0001, 2'd0);
    req_a = 4'b0000;
    tick(); exp_a("drop0", 4'b0000, 2'd0);
    tick(); exp_a("idle0", 4'b0000, 2'd0);

    // Single request, release, then ptr=3 wins with all requesting.
    req_a = 4'b0100;
    tick(); exp_a("single", 4'b0100, 2'd2);
    req_a = 4'b0000;
    tick(); exp_a("single_rel", 4'b0000, 2'd0);
    tick();
    req_a = 4'b1111;
    tick(); exp_a("ptr3", 4'b1000, 2'd3);
    req_a = 4'b0000;
    tick(); tick();

    // No competitor: grant held with no gap, then forced release to id 3.
    req_a = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      tick(); exp_a("solo", 4'b0010, 2'd1);
    end
    req_a = 4'b1010;
    tick(); exp_a("solo_rel", 4'b0000, 2'd0);
    tick(); exp_a("solo_next", 4'b1000, 2'd3);
    req_a = 4'b0000;
    tick(); tick();

    // Wrap: grant 2 (ptr->3), new requests rise as owner releases.
    req_a = 4'b0100;
    tick(); exp_a("wrap_own", 4'b0100, 2'd2);
    req_a = 4'b1001;
    tick(); exp_a("wrap_gap", 4'b0000, 2'd0);
    tick(); exp_a("wrap3", 4'b1000, 2'd3);
    for (int i = 0; i < 7; i++) begin
      tick(); exp_a("wrap3_hold", 4'b1000, 2'd3);
    end
    tick(); exp_a("force_gap", 4'b0000, 2'd0);
    tick(); exp_a("wrap0", 4'b0001, 2'd0);
    req_a = 4'b0000;
    tick(); tick();

    // Reset while id 2 holds with hold_cnt=5; ptr restarts at 0.
    req_a = 4'b0100;
    tick(); exp_a("mid_own", 4'b0100, 2'd2);
    for (int i = 0; i < 4; i++) tick();
    exp_a("mid_hold5", 4'b0100, 2'd2);
    rst_a = 1'b1;
    tick(); exp_a("mid_rst", 4'b0000, 2'd0);
    rst_a = 1'b0;
    req_a = 4'b1100;
    tick(); exp_a("post_rst", 4'b0100, 2'd2);

    // Round robin with MAX_HOLD=2 and all requesting.
    rst_b = 1'b0;
    req_b = 4'b1111;
    for (int i = 0; i < 13; i++) begin
      tick();
      chk($sformatf("rr%0d.gnt", i), 32'(gnt_b), 32'(rr_gnt[i]));
      chk($sformatf("rr%0d.valid", i), 32'(gv_b), 32'(|rr_gnt[i]));
      chk($sformatf("rr%0d.id", i), 32'(id_b), 32'(rr_id[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
